// File: rtl/uart_adapter_pkg.sv
// Shared register-map constants, FSM encodings and helpers for the UART adapter.
package uart_adapter_pkg;

    // Register select values decoded from addr_i[2]
    localparam logic UartDataOff = 1'b0;
    localparam logic UartStatOff = 1'b1;

    // STATUS register bit positions
    localparam int unsigned UartTxRdyBit    = 0;
    localparam int unsigned UartRxVldBit    = 1;
    localparam int unsigned UartOverrunBit  = 2;
    localparam int unsigned UartFrameErrBit = 3;
    localparam int unsigned UartTxBusyBit   = 4;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BUS_W  = 32;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_e;

    // Clock cycles per serial bit
    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; push while full is accepted only alongside a pop.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem_q[rd_ptr_q[IDX_W-1:0]];

    // Pointer update; extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_adapter.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs behind a request/ready bus port.
module uart_adapter
    import uart_adapter_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        txd,
    input  logic        rxd,
    output logic        int_o
);
    localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

    bus_state_e  bus_q, bus_d;
    ser_state_e  tx_q, tx_d, rx_q, rx_d;
    logic [BUS_W-1:0]  data_d, status;
    logic              ready_d, stat_clr;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [BYTE_W-1:0] tx_rdata, rx_rdata;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d, rcnt_q, rcnt_d;
    logic [2:0]        tbit_q, tbit_d, rbit_q, rbit_d;
    logic [BYTE_W-1:0] tsh_q, tsh_d, rsh_q, rsh_d;
    logic              txd_d;
    logic              overrun_q, frame_err_q, ov_set, fe_set;
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic              bus_unused;

    assign bus_unused = ^{addr_i[31:3], addr_i[1:0], sel_i[3:1], data_i[31:8]};

    uart_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst), .push(tx_push), .wr_data(data_i[7:0]),
        .pop(tx_pop), .rd_data(tx_rdata), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst), .push(rx_push), .wr_data(rsh_q),
        .pop(rx_pop), .rd_data(rx_rdata), .full(rx_full), .empty(rx_empty)
    );

    // Bus FSM: one FIFO access on IDLE->ACK, ready held until ce_i drops
    always_comb begin
        bus_d    = bus_q;
        ready_d  = 1'b0;
        data_d   = data_o;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        stat_clr = 1'b0;
        status   = '0;
        status[UartTxRdyBit]    = !tx_full;
        status[UartRxVldBit]    = !rx_empty;
        status[UartOverrunBit]  = overrun_q;
        status[UartFrameErrBit] = frame_err_q;
        status[UartTxBusyBit]   = (tx_q != SER_IDLE);
        unique case (bus_q)
            BUS_IDLE: begin
                data_d = '0;
                if (ce_i) begin
                    bus_d   = BUS_ACK;
                    ready_d = 1'b1;
                    if (addr_i[2] == UartDataOff) begin
                        if (we_i) begin
                            tx_push = sel_i[0];
                        end else begin
                            rx_pop = !rx_empty;
                            data_d = rx_empty ? '0 : BUS_W'(rx_rdata);
                        end
                    end else if (!we_i) begin
                        data_d   = status;
                        stat_clr = 1'b1;
                    end
                end
            end
            BUS_ACK: begin
                if (ce_i) begin
                    ready_d = 1'b1;
                end else begin
                    bus_d  = BUS_IDLE;
                    data_d = '0;
                end
            end
            default: bus_d = BUS_IDLE;
        endcase
    end

    // TX FSM: start, 8 data bits LSB first, stop; chains straight into the next byte
    always_comb begin
        tx_d   = tx_q;
        tcnt_d = tcnt_q + CNT_W'(1);
        tbit_d = tbit_q;
        tsh_d  = tsh_q;
        txd_d  = txd;
        tx_pop = 1'b0;
        unique case (tx_q)
            SER_IDLE: begin
                tcnt_d = '0;
                txd_d  = 1'b1;
                if (!tx_empty) begin
                    tx_pop = 1'b1;
                    tsh_d  = tx_rdata;
                    tx_d   = SER_START;
                    txd_d  = 1'b0;
                end
            end
            SER_START: begin
                if (tcnt_q == CNT_LAST) begin
                    tcnt_d = '0;
                    tbit_d = '0;
                    tx_d   = SER_DATA;
                    txd_d  = tsh_q[0];
                    tsh_d  = tsh_q >> 1;
                end
            end
            SER_DATA: begin
                if (tcnt_q == CNT_LAST) begin
                    tcnt_d = '0;
                    if (tbit_q == 3'd7) begin
                        tx_d  = SER_STOP;
                        txd_d = 1'b1;
                    end else begin
                        tbit_d = tbit_q + 3'd1;
                        txd_d  = tsh_q[0];
                        tsh_d  = tsh_q >> 1;
                    end
                end
            end
            SER_STOP: begin
                if (tcnt_q == CNT_LAST) begin
                    tcnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop = 1'b1;
                        tsh_d  = tx_rdata;
                        tx_d   = SER_START;
                        txd_d  = 1'b0;
                    end else begin
                        tx_d  = SER_IDLE;
                        txd_d = 1'b1;
                    end
                end
            end
            default: tx_d = SER_IDLE;
        endcase
    end

    // RX FSM: start-edge detect, glitch reject at half bit, mid-bit sampling
    always_comb begin
        rx_d    = rx_q;
        rcnt_d  = rcnt_q + CNT_W'(1);
        rbit_d  = rbit_q;
        rsh_d   = rsh_q;
        rx_push = 1'b0;
        fe_set  = 1'b0;
        unique case (rx_q)
            SER_IDLE: begin
                rcnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_d = SER_START;
            end
            SER_START: begin
                if (rcnt_q == CNT_HALF) begin
                    rcnt_d = '0;
                    rbit_d = '0;
                    rx_d   = rx_sync_q ? SER_IDLE : SER_DATA;
                end
            end
            SER_DATA: begin
                if (rcnt_q == CNT_LAST) begin
                    rcnt_d = '0;
                    rsh_d  = {rx_sync_q, rsh_q[7:1]};
                    if (rbit_q == 3'd7) rx_d = SER_STOP;
                    else                rbit_d = rbit_q + 3'd1;
                end
            end
            SER_STOP: begin
                if (rcnt_q == CNT_LAST) begin
                    rcnt_d  = '0;
                    rx_d    = SER_IDLE;
                    rx_push = rx_sync_q;
                    fe_set  = !rx_sync_q;
                end
            end
            default: rx_d = SER_IDLE;
        endcase
    end

    assign ov_set = rx_push && rx_full && !rx_pop;

    // State, datapath and sticky-flag registers; a flag set beats a status-read clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_q       <= BUS_IDLE;
            ready_o     <= 1'b0;
            data_o      <= '0;
            tx_q        <= SER_IDLE;
            tcnt_q      <= '0;
            tbit_q      <= '0;
            tsh_q       <= '0;
            txd         <= 1'b1;
            rx_q        <= SER_IDLE;
            rcnt_q      <= '0;
            rbit_q      <= '0;
            rsh_q       <= '0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            int_o       <= 1'b0;
        end else begin
            bus_q       <= bus_d;
            ready_o     <= ready_d;
            data_o      <= data_d;
            tx_q        <= tx_d;
            tcnt_q      <= tcnt_d;
            tbit_q      <= tbit_d;
            tsh_q       <= tsh_d;
            txd         <= txd_d;
            rx_q        <= rx_d;
            rcnt_q      <= rcnt_d;
            rbit_q      <= rbit_d;
            rsh_q       <= rsh_d;
            rx_meta_q   <= rxd;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            overrun_q   <= ov_set || (overrun_q && !stat_clr);
            frame_err_q <= fe_set || (frame_err_q && !stat_clr);
            int_o       <= !rx_empty;
        end
    end

endmodule

// File: tb/tb_uart_adapter.sv
// Directed bench for uart_adapter at DIV=16 with hand-computed expectations.
module tb_uart_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        ready_o;
    logic        txd;
    logic        rxd = 1'b1;
    logic        int_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] capq [$];

    always #5 clk = ~clk;

    uart_adapter #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
        .sel_i(sel_i), .data_i(data_i), .data_o(data_o), .ready_o(ready_o),
        .txd(txd), .rxd(rxd), .int_o(int_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus access; expects ready one cycle after ce_i and release one cycle after drop
    task automatic bus_xfer(input logic we, input logic stat, input logic [31:0] wdata,
                            input logic [3:0] sel, output logic [31:0] rdata);
        int n;
        @(negedge clk);
        ce_i = 1'b1; we_i = we; addr_i = {29'd0, stat, 2'b00}; sel_i = sel; data_i = wdata;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ready_o && n < 8);
        chk("ready_latency", n, 1);
        rdata = data_o;
        @(negedge clk);
        ce_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        chk("ready_release", ready_o, 0);
    endtask

    task automatic rd(input logic stat, output logic [31:0] r);
        bus_xfer(1'b0, stat, 32'd0, 4'h0, r);
    endtask

    task automatic wr(input logic [7:0] b);
        logic [31:0] r;
        bus_xfer(1'b1, 1'b0, {24'hFFFFFF, b}, 4'h1, r);
    endtask

    // Drive one 8N1 frame on rxd with the given stop-bit level
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk); rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge clk);
        end
        rxd = stop;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        logic [9:0]  txexp;
        int          lows;

        // Reset
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_ready", ready_o, 0);
        chk("rst_int", int_o, 0);
        chk("rst_data", data_o, 0);
        @(negedge clk); rst = 1'b1;
        rd(1'b1, r); chk("rst_status", r, 32'h01);

        // TX 0xA5: start, LSB-first data, stop; each bit exactly 16 cycles
        txexp = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; data_i = 32'hA5; sel_i = 4'h1;
        @(posedge clk); #1;
        chk("tx_ready_lat", ready_o, 1);
        chk("tx_idle_before", txd, 1);
        @(negedge clk); ce_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    chk($sformatf("tx_bit%0d_first", k), txd, txexp[k]);
                    repeat (15) @(posedge clk);
                    #1;
                    chk($sformatf("tx_bit%0d_last", k), txd, txexp[k]);
                    @(posedge clk); #1;
                end
            end
            begin
                logic [31:0] s;
                repeat (40) @(posedge clk);
                rd(1'b1, s); chk("tx_busy_status", s, 32'h11);
            end
        join
        chk("tx_after_txd", txd, 1);
        rd(1'b1, r); chk("tx_done_status", r, 32'h01);

        // RX 0x3C
        send_frame(8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("rx_int", int_o, 1);
        rd(1'b1, r); chk("rx_status", r, 32'h03);
        rd(1'b0, r); chk("rx_data", r, 32'h3C);
        rd(1'b1, r); chk("rx_status_after", r, 32'h01);
        chk("rx_int_clear", int_o, 0);

        // Framing error: stop bit low
        send_frame(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        rd(1'b1, r); chk("fe_status", r, 32'h09);
        rd(1'b1, r); chk("fe_status_clr", r, 32'h01);
        rd(1'b0, r); chk("fe_no_data", r, 32'h0);

        // Overrun: 17 frames, first 16 kept in order
        for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b1);
        repeat (4) @(negedge clk);
        rd(1'b1, r); chk("ov_status", r, 32'h07);
        for (int i = 0; i < 16; i++) begin
            rd(1'b0, r); chk($sformatf("ov_data%0d", i), r, 32'(8'h10 + i));
        end
        rd(1'b0, r); chk("ov_17th_lost", r, 32'h0);
        rd(1'b1, r); chk("ov_status_after", r, 32'h01);

        // TX full: first byte popped at once, 16 more fill the FIFO, the 18th store drops
        capq.delete();
        fork
            begin
                logic [31:0] s;
                wr(8'h00);
                for (int i = 1; i <= 17; i++) wr(8'(i));
                rd(1'b1, s); chk("txf_status_full", s, 32'h10);
            end
            begin : dec
                int         idle;
                logic [7:0] b;
                for (int f = 0; f < 20; f++) begin
                    idle = 0;
                    while (txd !== 1'b0 && idle < 400) begin
                        @(posedge clk); #1; idle++;
                    end
                    if (txd !== 1'b0) break;
                    repeat (8) @(posedge clk);
                    #1;
                    chk("txf_start_mid", txd, 0);
                    for (int i = 0; i < 8; i++) begin
                        repeat (16) @(posedge clk);
                        #1;
                        b[i] = txd;
                    end
                    repeat (16) @(posedge clk);
                    #1;
                    chk("txf_stop_mid", txd, 1);
                    capq.push_back(b);
                end
            end
        join
        chk("txf_frames", capq.size(), 17);
        for (int i = 0; i < capq.size() && i < 17; i++)
            chk($sformatf("txf_byte%0d", i), capq[i], 32'(i));
        rd(1'b1, r); chk("txf_status_end", r, 32'h01);

        // Reset mid-frame aborts TX immediately and discards queued bytes
        wr(8'h00);
        wr(8'h00);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_low_before", txd, 0);
        rst = 1'b0;
        #1;
        chk("midrst_txd", txd, 1);
        @(negedge clk); rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) lows++;
        end
        chk("midrst_line_idle", lows, 0);
        rd(1'b1, r); chk("midrst_status", r, 32'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
